// File: rtl/game_tick_sequencer_if.sv
// Start/done handshake between the tick sequencer and the game sub-units.
//   phase_start : one-cycle start pulse for the sub-unit selected by phase_id
//   phase_id    : 0 input, 1 move, 2 collide, 3 draw (held for the whole phase)
//   phase_done  : selected sub-unit has finished
//   hit         : collision result, qualified by phase_done while colliding
interface game_tick_sequencer_if;
  logic       phase_start;
  logic [1:0] phase_id;
  logic       phase_done;
  logic       hit;

  modport master (output phase_start, phase_id, input phase_done, hit);
  modport slave  (input phase_start, phase_id, output phase_done, hit);
endinterface

// File: rtl/game_tick_sequencer.sv
// Game frame sequencer. Each rising edge of the divided game clock starts one
// frame: input sample -> motion update -> collision check -> (wait vblank) ->
// draw, driven through a start/done handshake. Tracks game-over, score,
// ticks lost while a frame is still running, and phase timeouts.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   game_clk       : divided game clock level (async, synchronised here)
//   vblank         : VGA vertical blank level
//   run_en         : 1 run, 0 pause (only suppresses new frames)
//   restart        : one-cycle pulse, clears game state, back to idle
//   sub            : handshake to the sub-units (master side)
//   busy           : frame in progress
//   game_over      : sticky collision flag
//   score          : completed frames (saturating)
//   overrun_cnt    : ticks lost while busy (saturating)
//   timeout_err    : sticky phase-timeout flag
module game_tick_sequencer #(
  parameter int TIMEOUT = 50000,
  parameter int SCORE_W = 16,
  parameter int OVR_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  game_clk,
  input  logic                  vblank,
  input  logic                  run_en,
  input  logic                  restart,
  game_tick_sequencer_if.master sub,
  output logic                  busy,
  output logic                  game_over,
  output logic [SCORE_W-1:0]    score,
  output logic [OVR_W-1:0]      overrun_cnt,
  output logic                  timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INPUT, S_MOVE, S_COLLIDE, S_WAIT_VB, S_DRAW, S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 s1_q, s2_q, s3_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [OVR_W-1:0]     ovr_q, ovr_d;
  logic                 go_q, go_d;
  logic                 tmo_q, tmo_d;

  logic tick, first, done_ok, tmo_hit, timed, phase_st;

  // game_clk is asynchronous: two flops to settle, third for edge detect
  assign tick    = s2_q & ~s3_q;
  // timer is cleared on every state entry, so zero marks the first cycle
  assign first   = (timer_q == '0);
  // done is not trusted in the start cycle (may be stale from the last phase)
  assign done_ok = sub.phase_done & ~first;
  assign tmo_hit = (timer_q == TMO_LAST);
  assign timed   = (state_q inside {S_INPUT, S_MOVE, S_COLLIDE, S_WAIT_VB, S_DRAW});
  assign phase_st = (state_q inside {S_INPUT, S_MOVE, S_COLLIDE, S_DRAW});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      score_q <= '0;
      ovr_q   <= '0;
      go_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      s1_q    <= game_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      score_q <= score_d;
      ovr_q   <= ovr_d;
      go_q    <= go_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    ovr_d   = ovr_q;
    go_d    = go_q;
    tmo_d   = tmo_q;
    if (restart) begin
      // restart beats everything, including a coincident tick
      state_d = S_IDLE;
      score_d = '0;
      ovr_d   = '0;
      go_d    = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      if (tick && state_q != S_IDLE && state_q != S_OVER && ovr_q != '1)
        ovr_d = ovr_q + 1'b1;
      // exit condition is checked before the timeout so a late done still wins
      unique case (state_q)
        S_IDLE:    if (tick && run_en) state_d = S_INPUT;
        S_INPUT: begin
          if (done_ok)      state_d = S_MOVE;
          else if (tmo_hit) begin state_d = S_IDLE; tmo_d = 1'b1; end
        end
        S_MOVE: begin
          if (done_ok)      state_d = S_COLLIDE;
          else if (tmo_hit) begin state_d = S_IDLE; tmo_d = 1'b1; end
        end
        S_COLLIDE: begin
          if (done_ok) begin
            if (sub.hit) begin state_d = S_OVER; go_d = 1'b1; end
            else              state_d = S_WAIT_VB;
          end else if (tmo_hit) begin state_d = S_IDLE; tmo_d = 1'b1; end
        end
        S_WAIT_VB: begin
          if (vblank)       state_d = S_DRAW;
          else if (tmo_hit) begin state_d = S_IDLE; tmo_d = 1'b1; end
        end
        S_DRAW: begin
          if (done_ok) begin
            state_d = S_IDLE;
            if (score_q != '1) score_d = score_q + 1'b1;
          end else if (tmo_hit) begin state_d = S_IDLE; tmo_d = 1'b1; end
        end
        S_OVER:    state_d = S_OVER;
        default:   state_d = S_IDLE;
      endcase
    end
    timer_d = '0;
    if (state_d == state_q && timed) timer_d = timer_q + 1'b1;
  end

  always_comb begin
    unique case (state_q)
      S_MOVE:             sub.phase_id = 2'd1;
      S_COLLIDE:          sub.phase_id = 2'd2;
      S_WAIT_VB, S_DRAW:  sub.phase_id = 2'd3;
      default:            sub.phase_id = 2'd0;
    endcase
  end

  assign sub.phase_start = phase_st & first;
  assign busy            = (state_q != S_IDLE) && (state_q != S_OVER);
  assign game_over       = go_q;
  assign score           = score_q;
  assign overrun_cnt     = ovr_q;
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
module tb_game_tick_sequencer;
  localparam int TMO = 16;
  localparam int SW  = 16;
  localparam int OW  = 2;

  logic clock = 1'b0, reset_n = 1'b0, game_clk = 1'b0, vblank = 1'b0;
  logic run_en = 1'b0, restart = 1'b0;
  logic resp_done = 1'b0, hold_done = 1'b0, hit_d = 1'b0;
  logic hit_val = 1'b0, withhold_move = 1'b0;
  logic busy, game_over, timeout_err;
  logic [SW-1:0] score;
  logic [OW-1:0] overrun_cnt;

  int n_vec = 0, n_err = 0;
  int unsigned exp_q[$];

  game_tick_sequencer_if sif();
  assign sif.phase_done = resp_done | hold_done;
  assign sif.hit        = hit_d;

  game_tick_sequencer #(.TIMEOUT(TMO), .SCORE_W(SW), .OVR_W(OW)) dut (
    .clock(clock), .reset_n(reset_n), .game_clk(game_clk), .vblank(vblank),
    .run_en(run_en), .restart(restart), .sub(sif.master), .busy(busy),
    .game_over(game_over), .score(score), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sub-unit model: done two cycles after each start
  initial begin
    logic [1:0] id;
    forever begin
      @(negedge clock);
      if (sif.phase_start && !(withhold_move && sif.phase_id == 2'd1)) begin
        id = sif.phase_id;
        @(posedge clock); #1 resp_done = 1'b1; hit_d = (id == 2'd2) ? hit_val : 1'b0;
        @(posedge clock); #1 resp_done = 1'b0; hit_d = 1'b0;
      end
    end
  end

  // scoreboard: every start pulse must match the next expected phase id
  always @(negedge clock) begin
    if (sif.phase_start) begin
      if (exp_q.size() == 0) chk("ps_unexp", 1, 0);
      else                   chk("ps_id", sif.phase_id, exp_q.pop_front());
    end
  end

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  task automatic pulse_gclk();
    @(posedge clock); #1 game_clk = 1'b1;
    repeat (4) @(posedge clock);
    #1 game_clk = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  task automatic do_restart();
    @(posedge clock); #1 restart = 1'b1;
    @(posedge clock); #1 restart = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    @(negedge clock);
    while (busy && i < max) begin @(negedge clock); i++; end
    chk("idle_wait", busy, 0);
  endtask

  // waits for a start pulse with the given id; returns 1 if seen in time
  task automatic wait_start(input logic [1:0] id, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (sif.phase_start && sif.phase_id == id) found = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    // reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ps", sif.phase_start, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_score", score, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_go", game_over, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_id", sif.phase_id, 0);
    @(posedge clock); #1 reset_n = 1'b1; run_en = 1'b1; vblank = 1'b1;
    repeat (2) @(posedge clock);

    // normal frame with tick latency check
    push_frame(4);
    @(posedge clock); #1 game_clk = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("lat_pre_ps", sif.phase_start, 0);
    chk("lat_pre_busy", busy, 0);
    @(posedge clock); @(negedge clock);
    chk("lat_ps", sif.phase_start, 1);
    chk("lat_busy", busy, 1);
    game_clk = 1'b0;
    wait_idle(40);
    chk("nf_score", score, 1);
    chk("nf_ovr", overrun_cnt, 0);

    // collision: no draw phase, ticks in OVER ignored
    hit_val = 1'b1;
    push_frame(3);
    pulse_gclk();
    wait_idle(40);
    chk("col_go", game_over, 1);
    chk("col_score", score, 1);
    pulse_gclk();
    pulse_gclk();
    chk("over_score", score, 1);
    chk("over_ovr", overrun_cnt, 0);
    chk("over_busy", busy, 0);
    hit_val = 1'b0;
    do_restart();
    @(negedge clock);
    chk("rs_go", game_over, 0);
    chk("rs_score", score, 0);
    chk("rs_busy", busy, 0);

    // timeout in MOVE, exactly TMO cycles after entry
    withhold_move = 1'b1;
    push_frame(2);
    @(posedge clock); #1 game_clk = 1'b1;
    wait_start(2'd1, found);
    chk("tmo_mv_seen", found, 1);
    game_clk = 1'b0;
    repeat (TMO - 1) @(posedge clock);
    @(negedge clock);
    chk("tmo_pre_err", timeout_err, 0);
    chk("tmo_pre_busy", busy, 1);
    @(posedge clock); @(negedge clock);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_score", score, 0);
    withhold_move = 1'b0;
    push_frame(4);
    pulse_gclk();
    wait_idle(40);
    chk("tmo_nf_score", score, 1);
    chk("tmo_sticky", timeout_err, 1);

    // overrun saturation while parked in WAIT_VB
    vblank = 1'b0;
    push_frame(4);
    @(posedge clock); #1 game_clk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (busy && sif.phase_id == 2'd3) found = 1'b1;
    end
    chk("ov_wvb_seen", found, 1);
    @(posedge clock); #1 game_clk = 1'b0;
    repeat (5) begin
      @(posedge clock); #1 game_clk = 1'b1;
      @(posedge clock); #1 game_clk = 1'b0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("ov_sat", overrun_cnt, 3);
    chk("ov_busy", busy, 1);
    vblank = 1'b1;
    wait_idle(40);
    chk("ov_score", score, 2);
    do_restart();
    @(negedge clock);
    chk("ov_clr", overrun_cnt, 0);
    chk("ov_tmo_clr", timeout_err, 0);

    // pause: ticks dropped silently
    run_en = 1'b0;
    repeat (3) pulse_gclk();
    chk("pz_ovr", overrun_cnt, 0);
    chk("pz_busy", busy, 0);
    chk("pz_score", score, 0);
    // pause mid-frame: current frame completes
    run_en = 1'b1;
    push_frame(4);
    @(posedge clock); #1 game_clk = 1'b1;
    wait_start(2'd1, found);
    chk("pz_mv_seen", found, 1);
    run_en = 1'b0;
    game_clk = 1'b0;
    wait_idle(40);
    chk("pz_mid_score", score, 1);
    run_en = 1'b1;

    // async reset in DRAW, done held through release
    push_frame(4);
    @(posedge clock); #1 game_clk = 1'b1;
    wait_start(2'd3, found);
    chk("ar_draw_seen", found, 1);
    game_clk = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_score", score, 0);
    chk("ar_id", sif.phase_id, 0);
    chk("ar_ps", sif.phase_start, 0);
    hold_done = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("ar_post_busy", busy, 0);
    chk("ar_post_score", score, 0);
    hold_done = 1'b0;
    repeat (2) @(posedge clock);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/game_tick_sequencer.md
Name: game_tick_sequencer

Overview:
Sequences one game frame per rising edge of the divided game clock (the gameHz output of the frequency divider). Each frame runs four sub-unit phases in fixed order (input sample, motion update, collision check, draw) through a start/done handshake. The block tracks game-over, score, missed ticks and phase timeouts. It sits between the frequency divider and the game logic units (jump/obstacle/collision/renderer).

Parameters:
TIMEOUT, 50000, max clock cycles a phase (or vblank wait) may last before abort
SCORE_W, 16, width of score counter
OVR_W, 8, width of overrun counter

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
game_clk  input  1  divided game clock (level, asynchronous to clock)
vblank  input  1  VGA vertical blank level, clock domain
run_en  input  1  1 = run, 0 = pause
restart  input  1  one-cycle pulse, clears game state
phase_done  input  1  current sub-unit finished
hit  input  1  collision result, valid with phase_done in COLLIDE
phase_start  output  1  one-cycle start pulse to sub-unit
phase_id  output  2  0 input, 1 move, 2 collide, 3 draw
busy  output  1  state != IDLE and != OVER
game_over  output  1  sticky collision flag
score  output  SCORE_W  completed frames
overrun_cnt  output  OVR_W  ticks lost while busy
timeout_err  output  1  sticky phase-timeout flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; sync flops s1,s2,s3 = 0; timer 0.
- Tick detect: game_clk -> s1 -> s2 -> s3; tick = s2 & ~s3. State enters INPUT on the 3rd clock edge after game_clk goes high; phase_start is high during the cycle after that edge.
- States: IDLE, INPUT, MOVE, COLLIDE, WAIT_VB, DRAW, OVER.
- IDLE: on tick with run_en=1 -> INPUT. On tick with run_en=0, drop silently.
- Ticks in any non-IDLE state other than OVER: overrun_cnt += 1, saturating at all-ones. Ticks in OVER are ignored.
- Phase states (INPUT/MOVE/COLLIDE/DRAW):
  - phase_start=1 only in the first cycle of the state.
  - phase_id is held for the whole state. phase_id = 0 in IDLE/OVER; in WAIT_VB it holds 3.
  - phase_done is ignored in the phase_start cycle and honoured from the next cycle on.
- Transitions on done: INPUT -> MOVE -> COLLIDE.
- COLLIDE done: hit=1 -> OVER with game_over=1. hit=0 -> WAIT_VB.
- WAIT_VB: vblank=1 -> DRAW (can be the next cycle).
- DRAW done: score += 1, saturating at all-ones; -> IDLE.
- Timer: cleared on every state entry and incremented in INPUT/MOVE/COLLIDE/WAIT_VB/DRAW. If timer reaches TIMEOUT-1 without the exit condition: timeout_err=1 (sticky), -> IDLE, score unchanged. phase_done arriving in that same cycle wins over the timeout.
- run_en=0 mid-frame: the current frame completes; only new ticks are suppressed.
- OVER: waits only for restart.
- restart (any state, highest priority after reset): -> IDLE next edge; score, game_over, overrun_cnt, timeout_err cleared; no phase_start issued; a tick in the same cycle is dropped.
- A tick coinciding with the DRAW->IDLE exit cycle counts as overrun (state is not IDLE in that cycle).

Test Plan:
- Normal frame: reset, game_clk rise, sub-unit replies done 2 cycles after each start, hit=0, vblank=1 -> phase_start pulses with ids 0,1,2,3 in order; score=1; busy returns to 0.
- Collision: hit=1 with done in COLLIDE -> game_over=1, no draw phase; further game_clk edges leave score and overrun_cnt unchanged; restart -> game_over=0, score=0, IDLE.
- Timeout: TIMEOUT=16, withhold phase_done in MOVE -> timeout_err=1 exactly 16 cycles after MOVE entry; back to IDLE; next tick runs a full frame and score increments; timeout_err stays 1.
- Overrun/saturation: OVR_W=2, hold vblank=0 while 5 game_clk edges arrive -> overrun_cnt=3, saturated.
- Pause: run_en=0 with 3 ticks -> no phase_start, overrun_cnt=0. Drop run_en mid-MOVE -> frame still finishes, score +1.
- Async reset mid-DRAW: reset_n low without a clock edge -> outputs 0 and state IDLE immediately; phase_done held high after release -> no spurious transition.
